dmem_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers the pipeline's MEM-stage load/store requests and stalls the pipeline via `mem_ready`. On a miss or any store it acts as initiator toward a multi-cycle backing memory over a req/ack handshake. It sits between the MEM stage and main data memory; the pipeline registers freeze while `mem_ready` is low.

---
 rtl/dmem_cache.sv | 126 ++++++++++++
 tb/tb_dmem_cache.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Stalls the pipeline through mem_ready while refilling a line or writing through.
module dmem_cache #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        m2reg,
  input  logic        wmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack
);
  localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;

  logic [1:0]             state;
  logic [OFFSET_BITS-1:0] cnt;
  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    ref_tag;
  logic [INDEX_BITS-1:0]  ref_index;
  logic [TAG_BITS-1:0]    tags  [LINES];
  logic [31:0]            words [LINES*WORDS];

  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit;
  logic                   store;
  logic                   load;
  logic                   last;
  logic                   unused_bits;

  assign offset      = addr[OFFSET_BITS+1:2];
  assign index       = addr[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
  assign tag         = addr[31:OFFSET_BITS+INDEX_BITS+2];
  assign unused_bits = ^addr[1:0];
  assign hit         = valid[index] && (tags[index] == tag);
  assign store       = wmem;
  assign load        = m2reg && !wmem;
  assign last        = &cnt;
  assign rdata       = words[{index, offset}];

  always_comb begin
    mem_ready = 1'b1;
    mreq      = 1'b0;
    mwe       = 1'b0;
    maddr     = '0;
    mwdata    = '0;
    case (state)
      IDLE: mem_ready = !store && !(load && !hit);
      REFILL: begin
        mem_ready = 1'b0;
        mreq      = 1'b1;
        maddr     = {ref_tag, ref_index, cnt, 2'b00};
      end
      WRITE: begin
        // Store retires on the same edge memory accepts it.
        mem_ready = mack;
        mreq      = 1'b1;
        mwe       = 1'b1;
        maddr     = {addr[31:2], 2'b00};
        mwdata    = wdata;
      end
      default: mem_ready = 1'b0;
    endcase
  end

  // Line address is latched at the miss so a dropped request still refills one coherent line.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      ref_tag   <= '0;
      ref_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store) begin
            state <= WRITE;
          end else if (load && !hit) begin
            state        <= REFILL;
            cnt          <= '0;
            valid[index] <= 1'b0;
            ref_tag      <= tag;
            ref_index    <= index;
          end
        end
        REFILL: begin
          if (mack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              valid[ref_index] <= 1'b1;
              state            <= IDLE;
            end
          end
        end
        WRITE: if (mack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == REFILL && mack) begin
      words[{ref_index, cnt}] <= mrdata;
      if (last) tags[ref_index] <= ref_tag;
    end else if (state == WRITE && mack && hit) begin
      words[{index, offset}] <= wdata;
    end
  end
endmodule

// File: tb/tb_dmem_cache.sv
// Self-checking bench for dmem_cache: a latency-programmable backing memory
// plus a line-level reference model of valid/tag state and memory contents.
module tb_dmem_cache;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        m2reg = 1'b0;
  logic        wmem = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata = '0;
  logic        mack = 1'b0;

  int checks = 0;
  int errors = 0;

  dmem_cache #(.INDEX_BITS(4), .OFFSET_BITS(2)) dut (
    .clock(clock), .resetn(resetn), .m2reg(m2reg), .wmem(wmem), .addr(addr),
    .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready), .mreq(mreq), .mwe(mwe),
    .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata), .mack(mack)
  );

  always #5 clock = ~clock;

  logic [31:0] dev_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  bit          mvalid [16];
  logic [23:0] mtag [16];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Backing memory: acks the lat-th cycle of each held request.
  int lat = 1;
  int wcnt = 0;
  always @(negedge clock) begin
    if (!resetn || !mreq) begin
      mack = 1'b0;
      wcnt = 0;
    end else begin
      wcnt++;
      if (wcnt >= lat) begin
        mack = 1'b1;
        wcnt = 0;
        if (mwe) dev_mem[maddr] = mwdata;
        else mrdata = dev_rd(maddr);
      end else begin
        mack = 1'b0;
      end
    end
  end

  // Reference model: whole-line allocation on load miss, never on store.
  function automatic bit mhit(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
  endfunction

  function automatic int exp_cycles(input bit st, input logic [31:0] a, input int l);
    if (st) return l + 1;
    return mhit(a) ? 1 : 4 * l + 2;
  endfunction

  task automatic model_commit(input bit st, input logic [31:0] a, input logic [31:0] d);
    if (st) ref_mem[a] = d;
    else if (!mhit(a)) begin
      mvalid[a[7:4]] = 1'b1;
      mtag[a[7:4]]   = a[31:8];
    end
  endtask

  logic [31:0] acked[$];
  int          req_cycles;
  logic        ack_we;
  logic [31:0] ack_wdata;

  // Drives one request from just after a rising edge until it retires.
  task automatic run_op(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d,
                        input int l, output int cyc, output logic [31:0] rd);
    lat = l; addr = a; wdata = d; m2reg = ld; wmem = st;
    acked.delete(); req_cycles = 0; ack_we = 1'b0; ack_wdata = '0;
    cyc = -1; rd = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock); #2;
      if (mreq) req_cycles++;
      if (mreq && mack) begin
        acked.push_back(maddr);
        ack_we = mwe;
        ack_wdata = mwdata;
      end
      if (mem_ready) begin
        cyc = i;
        rd = rdata;
        break;
      end
    end
    @(posedge clock); #1;
    m2reg = 1'b0; wmem = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b want 0", mreq); end
    checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL reset_mwe got %b want 0", mwe); end
    checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL reset_maddr got %h want 0", maddr); end
    checks++; if (mwdata !== 32'h0) begin errors++; $display("FAIL reset_mwdata got %h want 0", mwdata); end
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    @(negedge clock); #2;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", mem_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_load_miss();
    int cyc; logic [31:0] rd; logic [31:0] got;
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 1, cyc, rd);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL miss_cycles got %0d want 6", cyc); end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL miss_req_cycles got %0d want 4", req_cycles); end
    for (int k = 0; k < 4; k++) begin
      got = (acked.size() > k) ? acked[k] : 32'hxxxxxxxx;
      checks++;
      if (got !== 32'h100 + 32'(4 * k)) begin
        errors++; $display("FAIL miss_maddr%0d got %h want %h", k, got, 32'h100 + 32'(4 * k));
      end
    end
    checks++; if (rd !== ref_rd(32'h100)) begin errors++; $display("FAIL miss_rdata got %h want %h", rd, ref_rd(32'h100)); end
    model_commit(1'b0, 32'h100, 32'h0);
  endtask

  task automatic test_load_hit();
    int cyc; logic [31:0] rd;
    run_op(1'b1, 1'b0, 32'h108, 32'h0, 1, cyc, rd);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_cycles got %0d want 1", cyc); end
    checks++; if (req_cycles !== 0) begin errors++; $display("FAIL hit_mreq got %0d want 0", req_cycles); end
    checks++; if (rd !== ref_rd(32'h108)) begin errors++; $display("FAIL hit_rdata got %h want %h", rd, ref_rd(32'h108)); end
  endtask

  task automatic test_store_hit();
    int cyc; logic [31:0] rd;
    run_op(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 3, cyc, rd);
    model_commit(1'b1, 32'h104, 32'hDEADBEEF);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL st_hit_cycles got %0d want 4", cyc); end
    checks++; if (req_cycles !== 3) begin errors++; $display("FAIL st_hit_req got %0d want 3", req_cycles); end
    checks++; if (ack_we !== 1'b1) begin errors++; $display("FAIL st_hit_mwe got %b want 1", ack_we); end
    checks++; if (acked.size() !== 1 || acked[0] !== 32'h104) begin
      errors++; $display("FAIL st_hit_maddr got %0d transfers first %h want 1 at 00000104", acked.size(), acked.size() > 0 ? acked[0] : 32'h0);
    end
    checks++; if (dev_rd(32'h104) !== 32'hDEADBEEF) begin errors++; $display("FAIL st_hit_memory got %h want deadbeef", dev_rd(32'h104)); end
    run_op(1'b1, 1'b0, 32'h104, 32'h0, 1, cyc, rd);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL st_hit_reload_cycles got %0d want 1", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL st_hit_reload_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_store_miss();
    int cyc; logic [31:0] rd;
    run_op(1'b0, 1'b1, 32'h2000, 32'h13579BDF, 2, cyc, rd);
    model_commit(1'b1, 32'h2000, 32'h13579BDF);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL st_miss_cycles got %0d want 3", cyc); end
    checks++; if (ack_wdata !== 32'h13579BDF) begin errors++; $display("FAIL st_miss_mwdata got %h want 13579bdf", ack_wdata); end
    run_op(1'b1, 1'b0, 32'h2000, 32'h0, 1, cyc, rd);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL st_miss_load_cycles got %0d want 6", cyc); end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL st_miss_load_req got %0d want 4", req_cycles); end
    checks++; if (rd !== 32'h13579BDF) begin errors++; $display("FAIL st_miss_load_rdata got %h want 13579bdf", rd); end
    model_commit(1'b0, 32'h2000, 32'h0);
  endtask

  task automatic test_conflict();
    int cyc; logic [31:0] rd; int want;
    logic [31:0] seq [4];
    seq = '{32'h200, 32'h100, 32'h200, 32'h100};
    foreach (seq[k]) begin
      want = exp_cycles(1'b0, seq[k], 1);
      run_op(1'b1, 1'b0, seq[k], 32'h0, 1, cyc, rd);
      checks++; if (cyc !== want || (k > 0 && cyc !== 6)) begin errors++; $display("FAIL conflict%0d_cycles got %0d want 6", k, cyc); end
      checks++; if (rd !== ref_rd(seq[k])) begin errors++; $display("FAIL conflict%0d_rdata got %h want %h", k, rd, ref_rd(seq[k])); end
      model_commit(1'b0, seq[k], 32'h0);
    end
  endtask

  task automatic test_reset_abort();
    int cyc; logic [31:0] rd; logic [31:0] got;
    run_op(1'b1, 1'b0, 32'h200, 32'h0, 1, cyc, rd);
    model_commit(1'b0, 32'h200, 32'h0);
    lat = 1; addr = 32'h100; m2reg = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    checks++; if (mreq !== 1'b1 || maddr !== 32'h104) begin errors++; $display("FAIL abort_pre got mreq %b maddr %h want 1 00000104", mreq, maddr); end
    resetn = 1'b0;
    #1;
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL abort_mreq got %b want 0", mreq); end
    checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL abort_maddr got %h want 0", maddr); end
    m2reg = 1'b0;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 1, cyc, rd);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL abort_reload_cycles got %0d want 6", cyc); end
    got = (acked.size() > 0) ? acked[0] : 32'hxxxxxxxx;
    checks++; if (acked.size() !== 4 || got !== 32'h100) begin errors++; $display("FAIL abort_reload_words got %0d from %h want 4 from 00000100", acked.size(), got); end
    checks++; if (rd !== ref_rd(32'h100)) begin errors++; $display("FAIL abort_reload_rdata got %h want %h", rd, ref_rd(32'h100)); end
    model_commit(1'b0, 32'h100, 32'h0);
    run_op(1'b1, 1'b0, 32'h200, 32'h0, 1, cyc, rd);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL abort_other_cycles got %0d want 6", cyc); end
    model_commit(1'b0, 32'h200, 32'h0);
  endtask

  task automatic test_random();
    int cyc; logic [31:0] rd; int want; bit ld; bit st; int l;
    logic [31:0] a; logic [31:0] d;
    for (int n = 0; n < 60; n++) begin
      a  = (32'($urandom_range(0, 3) + 8'h40) << 8) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      d  = $urandom;
      st = ($urandom_range(0, 2) == 0);
      ld = st ? ($urandom_range(0, 1) == 1) : 1'b1;
      l  = $urandom_range(1, 3);
      want = exp_cycles(st, a, l);
      run_op(ld, st, a, d, l, cyc, rd);
      model_commit(st, a, d);
      checks++; if (cyc !== want) begin errors++; $display("FAIL rand%0d_cycles addr %h st %b got %0d want %0d", n, a, st, cyc, want); end
      if (st) begin
        checks++; if (dev_rd(a) !== d) begin errors++; $display("FAIL rand%0d_memory addr %h got %h want %h", n, a, dev_rd(a), d); end
      end else begin
        checks++; if (rd !== ref_rd(a)) begin errors++; $display("FAIL rand%0d_rdata addr %h got %h want %h", n, a, rd, ref_rd(a)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
